// File: rtl/encode_pkg.sv
// Shared definitions for the encoder arbiter: default parameters and FSM state encoding.
package encode_pkg;

  localparam int N_REQ_DEF     = 4;
  localparam int DW_DEF        = 64;
  localparam int MSG_BEATS_DEF = 16;
  localparam int TO_CYC_DEF    = 1023;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_WAIT_ENC = 3'd3,
    ST_PARITY   = 3'd4,
    ST_RELEASE  = 3'd5
  } state_t;

  // Index width that stays at least one bit for single-entry cases.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/encode_arbiter_rr_pick.sv
// Round-robin selector: first set request at or after ptr, wrapping, as a one-hot vector.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] pick
);

  logic w_found;

  // Scan requesters in priority order starting from ptr; keep only the first hit.
  always_comb begin
    pick    = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!w_found && req[j] && (j == ((int'(ptr) + k) % N_REQ))) begin
          pick[j] = 1'b1;
          w_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/encode_arbiter.sv
// Shares one encoder between several flash channels: round-robin frame ownership,
// beat forwarding, parity handshake and a watchdog on the encoder-wait phases.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no owner; picks the next requester round-robin
// START    | one-cycle en_start pulse to the encoder, beat count cleared
// DATA     | forwarding owner beats until MSG_BEATS are accepted
// WAIT_ENC | waiting for done_encode (watchdog running)
// PARITY   | parity read issued, waiting for parity_out_done (watchdog running)
// RELEASE  | frame_done to owner, round-robin pointer advanced
module encode_arbiter
  import encode_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int MSG_BEATS = MSG_BEATS_DEF,
  parameter int TO_CYC    = TO_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    din_valid,
  input  logic [N_REQ*DW-1:0] din,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    frame_done,
  output logic                err_timeout,
  output logic                busy,
  output logic                en_start,
  output logic                en_din,
  output logic [DW-1:0]       enc_din,
  output logic                read_parity,
  input  logic                done_encode,
  input  logic                parity_out_done
);

  localparam int PW = idx_w(N_REQ);
  localparam int BW = $clog2(MSG_BEATS + 1);
  localparam int WW = $clog2(TO_CYC + 1);

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_owner, w_owner_nxt;
  logic [PW-1:0]    r_rr_ptr, w_rr_nxt;
  logic [BW-1:0]    r_beat_cnt, w_beat_nxt;
  logic [WW-1:0]    r_wd, w_wd_nxt;

  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [N_REQ-1:0] r_frame_done, w_fd_nxt;
  logic             r_err_timeout, w_to_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_en_start, w_start_nxt;
  logic             r_en_din, w_en_din_nxt;
  logic [DW-1:0]    r_enc_din, w_enc_din_nxt;
  logic             r_read_parity, w_rp_nxt;

  logic [N_REQ-1:0] w_pick;
  logic [PW-1:0]    w_pick_idx;
  logic [N_REQ-1:0] w_owner_oh;
  logic             w_valid_own;
  logic [DW-1:0]    w_din_own;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_pick (
    .req  (req),
    .ptr  (r_rr_ptr),
    .pick (w_pick)
  );

  assign w_owner_oh  = N_REQ'(1) << r_owner;
  assign w_valid_own = din_valid[r_owner];
  assign w_din_own   = din[r_owner*DW +: DW];

  // One-hot pick to binary owner index.
  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick[i]) w_pick_idx = PW'(i);
    end
  end

  // Next-state and next-output decode; outputs are registered from these values.
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_rr_nxt      = r_rr_ptr;
    w_beat_nxt    = r_beat_cnt;
    w_wd_nxt      = r_wd;
    w_grant_nxt   = r_grant;
    w_fd_nxt      = '0;
    w_to_nxt      = 1'b0;
    w_en_din_nxt  = 1'b0;
    w_enc_din_nxt = r_enc_din;
    w_rp_nxt      = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_owner_nxt = w_pick_idx;
          w_grant_nxt = w_pick;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_beat_nxt  = '0;
        w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_valid_own) begin
          w_en_din_nxt  = 1'b1;
          w_enc_din_nxt = w_din_own;
          w_beat_nxt    = r_beat_cnt + BW'(1);
          if (r_beat_cnt == BW'(MSG_BEATS - 1)) begin
            w_wd_nxt    = '0;
            w_state_nxt = ST_WAIT_ENC;
          end
        end
      end
      ST_WAIT_ENC: begin
        if (done_encode) begin
          w_rp_nxt    = 1'b1;
          w_wd_nxt    = '0;
          w_state_nxt = ST_PARITY;
        end else if (r_wd == WW'(TO_CYC - 1)) begin
          w_to_nxt    = 1'b1;
          w_fd_nxt    = w_owner_oh;
          w_grant_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_wd_nxt = r_wd + WW'(1);
        end
      end
      ST_PARITY: begin
        if (parity_out_done) begin
          w_fd_nxt    = w_owner_oh;
          w_grant_nxt = '0;
          w_state_nxt = ST_RELEASE;
        end else if (r_wd == WW'(TO_CYC - 1)) begin
          w_to_nxt    = 1'b1;
          w_fd_nxt    = w_owner_oh;
          w_grant_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_wd_nxt = r_wd + WW'(1);
        end
      end
      ST_RELEASE: begin
        w_rr_nxt    = (r_owner == PW'(N_REQ - 1)) ? '0 : r_owner + PW'(1);
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_start_nxt = (w_state_nxt == ST_START);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
  end

  // State, bookkeeping and registered outputs; reset clears everything mid-frame too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_owner       <= '0;
      r_rr_ptr      <= '0;
      r_beat_cnt    <= '0;
      r_wd          <= '0;
      r_grant       <= '0;
      r_frame_done  <= '0;
      r_err_timeout <= 1'b0;
      r_busy        <= 1'b0;
      r_en_start    <= 1'b0;
      r_en_din      <= 1'b0;
      r_enc_din     <= '0;
      r_read_parity <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_owner       <= w_owner_nxt;
      r_rr_ptr      <= w_rr_nxt;
      r_beat_cnt    <= w_beat_nxt;
      r_wd          <= w_wd_nxt;
      r_grant       <= w_grant_nxt;
      r_frame_done  <= w_fd_nxt;
      r_err_timeout <= w_to_nxt;
      r_busy        <= w_busy_nxt;
      r_en_start    <= w_start_nxt;
      r_en_din      <= w_en_din_nxt;
      r_enc_din     <= w_enc_din_nxt;
      r_read_parity <= w_rp_nxt;
    end
  end

  assign grant       = r_grant;
  assign frame_done  = r_frame_done;
  assign err_timeout = r_err_timeout;
  assign busy        = r_busy;
  assign en_start    = r_en_start;
  assign en_din      = r_en_din;
  assign enc_din     = r_enc_din;
  assign read_parity = r_read_parity;

endmodule

// File: doc/encode_arbiter.md
ENCODE_ARBITER -- requirements
Module: encode_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of flash-channel requesters sharing one encoder.
REQ-002 Parameter DW, default 64, message beat width in bits.
REQ-003 Parameter MSG_BEATS, default 16, message beats per codeword.
REQ-004 Parameter TO_CYC, default 1023, watchdog limit in cycles for the encoder-wait phases.
REQ-005 clk  input  1  single clock; all state on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-007 req  input  N_REQ  per-requester frame request, level.
REQ-008 din_valid  input  N_REQ  per-requester message beat valid.
REQ-009 din  input  N_REQ*DW  packed beats; requester i at bits [i*DW +: DW].
REQ-010 grant  output  N_REQ  one-hot owner; all-zero when no owner.
REQ-011 frame_done  output  N_REQ  one-cycle pulse to the owner at frame release.
REQ-012 err_timeout  output  1  one-cycle pulse on watchdog expiry.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 en_start  output  1  one-cycle start pulse to the encoder controller.
REQ-015 en_din  output  1  beat valid to the encoder controller.
REQ-016 enc_din  output  DW  beat data to the encoder datapath.
REQ-017 read_parity  output  1  one-cycle parity read request to the encoder controller.
REQ-018 done_encode  input  1  encoder idle-with-result indication.
REQ-019 parity_out_done  input  1  parity transfer complete.

Function
REQ-020 The FSM SHALL have states IDLE, START, DATA, WAIT_ENC, PARITY and RELEASE, with registered outputs.
REQ-021 In IDLE with any req bit set, the block SHALL take the first set bit at or after rr_ptr (wrapping), register it as owner, set grant, and move to START.
REQ-022 START SHALL last one cycle with en_start=1, then move to DATA.
REQ-023 In DATA, each cycle with din_valid[owner]=1 SHALL be accepted, driving en_din=1 and enc_din=din[owner] one cycle later, and incrementing beat_cnt.
REQ-024 din_valid from non-owners SHALL be ignored, as shall din_valid[owner] after MSG_BEATS beats are accepted.
REQ-025 On the MSG_BEATS-th accepted beat, the FSM SHALL move to WAIT_ENC; en_din SHALL NOT be high in the same cycle as read_parity.
REQ-026 In WAIT_ENC with done_encode=1, the block SHALL pulse read_parity for one cycle and move to PARITY.
REQ-027 In PARITY with parity_out_done=1, the FSM SHALL move to RELEASE.
REQ-028 RELEASE SHALL last one cycle: pulse frame_done[owner], clear grant, set rr_ptr=(owner+1) mod N_REQ, and return to IDLE.
REQ-029 The watchdog SHALL clear on entry to WAIT_ENC and PARITY and count each cycle in those states; on reaching TO_CYC it SHALL pulse err_timeout and frame_done[owner], clear grant, and return to IDLE without advancing beat data.
REQ-030 A req drop by the owner mid-frame SHALL NOT abort the frame; grant SHALL be held until RELEASE or timeout.
REQ-031 done_encode and parity_out_done SHALL be ignored outside WAIT_ENC and PARITY respectively.
REQ-032 beat_cnt SHALL be $clog2(MSG_BEATS+1) bits wide and clear in START.

Reset
REQ-033 On rst_n low, the FSM SHALL go to IDLE, rr_ptr, beat_cnt, watchdog and owner to 0, and every output to 0, including mid-frame; the encoder controller's own reset SHALL be relied on for its state.

Structure
REQ-034 State encoding and the default parameter values SHALL reside in the shared package encode_pkg.
REQ-035 Round-robin selection SHALL be the sub-module rr_pick (inputs req, ptr; output one-hot pick); the data mux and FSM SHALL stay in encode_arbiter.

Verification
REQ-036 req=4'b1111 after reset, each frame 16 beats with prompt handshakes -> grant order 0,1,2,3,0, one frame_done each.
REQ-037 Owner 2 sends 20 valid beats -> exactly 16 en_din pulses, and enc_din matches beats 1-16 delayed one cycle.
REQ-038 done_encode held 0 for 1023 cycles in WAIT_ENC -> err_timeout pulse, grant=0, IDLE next cycle.
REQ-039 rst_n low during DATA at beat 7 -> all outputs 0 within the same cycle, and the next frame starts from requester 0.
REQ-040 Owner drops req at beat 3 while requester 1 requests -> frame completes, then requester 1 is granted; parity_out_done pulsed in DATA -> no effect.
